// File: rtl/bf16_pkg.sv
// bf16_pkg: shared BF16 constants, field layout and accumulator FSM states.
//   bf16_t      - packed {sign, exp[7:0], frac[6:0]} view of a BF16 word
//   acc_state_t - accumulator FSM states {IDLE, ACCUM, DONE}
package bf16_pkg;

  localparam int unsigned BF16_EXP_BIAS = 127;
  localparam int unsigned BF16_EXP_W    = 8;
  localparam int unsigned BF16_FRAC_W   = 7;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_PINF = 16'h7F80;
  localparam logic [15:0] BF16_NINF = 16'hFF80;

  typedef struct packed {
    logic                   sign;
    logic [BF16_EXP_W-1:0]  exp;
    logic [BF16_FRAC_W-1:0] frac;
  } bf16_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } acc_state_t;

endpackage

// File: rtl/bf16_adder.sv
// bf16_adder: combinational BF16 adder, round toward zero, subnormals flushed.
// Ports:
//   a, b : BF16 operands
//   sum  : BF16 result
module bf16_adder
  import bf16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  bf16_t op_a, op_b, big, sml;
  logic  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic  a_big;

  // 8b mantissa (hidden bit included) followed by 3 guard bits.
  logic [10:0] big_m, sml_m, sml_sh, sub_m, norm_m;
  logic [11:0] add_m;
  logic [7:0]  exp_diff;
  logic [3:0]  lz;
  logic signed [9:0] res_e;
  logic [6:0]  res_frac;
  logic        unused_bits;

  assign op_a = a;
  assign op_b = b;

  assign a_zero = (op_a.exp == 8'h00);
  assign b_zero = (op_b.exp == 8'h00);
  assign a_inf  = (op_a.exp == 8'hFF) && (op_a.frac == 7'h00);
  assign b_inf  = (op_b.exp == 8'hFF) && (op_b.frac == 7'h00);
  assign a_nan  = (op_a.exp == 8'hFF) && (op_a.frac != 7'h00);
  assign b_nan  = (op_b.exp == 8'hFF) && (op_b.frac != 7'h00);

  // Order by magnitude so the subtraction below never goes negative.
  assign a_big = {op_a.exp, op_a.frac} >= {op_b.exp, op_b.frac};
  assign big   = a_big ? op_a : op_b;
  assign sml   = a_big ? op_b : op_a;

  assign big_m    = {1'b1, big.frac, 3'b000};
  assign sml_m    = {1'b1, sml.frac, 3'b000};
  assign exp_diff = big.exp - sml.exp;
  assign sml_sh   = (exp_diff > 8'd10) ? 11'h000 : (sml_m >> exp_diff);

  assign add_m = {1'b0, big_m} + {1'b0, sml_sh};
  assign sub_m = big_m - sml_sh;

  // Leading-zero count of the difference; the highest set bit wins.
  always_comb begin
    lz = 4'd0;
    for (int i = 0; i <= 10; i++) begin
      if (sub_m[i]) lz = 4'(10 - i);
    end
  end

  assign norm_m = sub_m << lz;

  always_comb begin
    res_e    = $signed({2'b00, big.exp});
    res_frac = 7'h00;
    if (big.sign == sml.sign) begin
      if (add_m[11]) begin
        res_e    = $signed({2'b00, big.exp}) + 10'sd1;
        res_frac = add_m[10:4];
      end else begin
        res_frac = add_m[9:3];
      end
    end else begin
      res_e    = $signed({2'b00, big.exp}) - $signed({6'b000000, lz});
      res_frac = norm_m[9:3];
    end
  end

  assign unused_bits = ^{add_m[2:0], norm_m[10], norm_m[2:0]};

  always_comb begin
    sum = 16'h0000;
    if (a_nan || b_nan) begin
      sum = BF16_QNAN;
    end else if (a_inf && b_inf && (op_a.sign != op_b.sign)) begin
      sum = BF16_QNAN;
    end else if (a_inf) begin
      sum = a;
    end else if (b_inf) begin
      sum = b;
    end else if (a_zero && b_zero) begin
      sum = {op_a.sign & op_b.sign, 15'h0000};
    end else if (b_zero) begin
      sum = a;
    end else if (a_zero) begin
      sum = b;
    end else if ((big.sign != sml.sign) && (sub_m == 11'h000)) begin
      sum = 16'h0000;
    end else if (res_e <= 10'sd0) begin
      sum = {big.sign, 15'h0000};
    end else if (res_e >= 10'sd255) begin
      sum = big.sign ? BF16_NINF : BF16_PINF;
    end else begin
      sum = {big.sign, res_e[7:0], res_frac};
    end
  end

endmodule

// File: rtl/bf16_accumulator.sv
// bf16_accumulator: sums ACC_LEN BF16 products into one BF16 result.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : product handshake, in_data = BF16 product
//   in_clear            : synchronous abort, same effect as reset
//   out_valid/out_ready : result handshake, out_data = BF16 sum (held until taken)
module bf16_accumulator
  import bf16_pkg::*;
#(
  parameter  int unsigned ACC_LEN = 16,
  localparam int unsigned CNT_W   = $clog2(ACC_LEN) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  acc_state_t       state;
  logic [15:0]      acc;
  logic [15:0]      sum;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  bf16_adder u_adder (
    .a   (acc),
    .b   (in_data),
    .sum (sum)
  );

  assign in_ready = (state != DONE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= 16'h0000;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
    end else if (in_clear) begin
      state     <= IDLE;
      acc       <= 16'h0000;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc <= in_data;
            cnt <= CNT_W'(1);
            if (ACC_LEN == 1) begin
              out_data  <= in_data;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= sum;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(ACC_LEN - 1)) begin
              out_data  <= sum;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_accumulator.sv
// tb_bf16_accumulator: directed bench for bf16_accumulator (ACC_LEN=4 and ACC_LEN=1).
module tb_bf16_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_clear, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic        v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready;
  logic [15:0] v1_in_data, v1_out_data;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  bf16_accumulator #(.ACC_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_clear  (in_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  bf16_accumulator #(.ACC_LEN(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1_in_valid),
    .in_ready  (v1_in_ready),
    .in_data   (v1_in_data),
    .in_clear  (1'b0),
    .out_valid (v1_out_valid),
    .out_ready (v1_out_ready),
    .out_data  (v1_out_data)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product and return #1 after the edge that accepts it.
  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("send_timeout", {15'h0, in_ready}, 16'h0001);
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for a result, check it, then drain it with out_ready.
  task automatic collect(input string tag, input logic [15:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {15'h0, out_valid}, 16'h0001);
    check({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    tick();
    check({tag, "_drain"}, {15'h0, out_valid}, 16'h0000);
    check({tag, "_ready"}, {15'h0, in_ready}, 16'h0001);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_clear = 1'b0; out_ready = 1'b1;
    v1_in_valid = 1'b0; v1_in_data = 16'h0; v1_out_ready = 1'b0;
    #12;
    check("rst_out_valid", {15'h0, out_valid}, 16'h0000);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_in_ready", {15'h0, in_ready}, 16'h0001);
    rst_n = 1'b1;
    tick();

    // 1: back-to-back 1.0 x4 -> 4.0, latency boundary
    send(16'h3F80); send(16'h3F80); send(16'h3F80);
    check("t1_not_early", {15'h0, out_valid}, 16'h0000);
    send(16'h3F80);
    check("t1_in_ready_done", {15'h0, in_ready}, 16'h0000);
    collect("t1", 16'h4080);

    // 2: cancellation, inf-inf NaN (sticky), overflow, normalising subtraction
    send(16'h4000); send(16'hC000); send(16'h3F80); send(16'hBF80);
    collect("t2_cancel", 16'h0000);
    send(16'h7F80); send(16'hFF80); send(16'h3F80); send(16'h3F80);
    collect("t2_nan", 16'h7FC0);
    send(16'h7F00); send(16'h7F00); send(16'h0000); send(16'h3F80);
    collect("t2_ovf", 16'h7F80);
    send(16'h4040); send(16'hBF80); send(16'hBF00); send(16'hC000);
    collect("t2_sub", 16'hBF00);

    // 3: output back-pressure with in_valid held high
    out_ready = 1'b0;
    send(16'h3F80); send(16'h3F80); send(16'h3F80); send(16'h3F80);
    in_valid = 1'b1;
    in_data  = 16'h4000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", {15'h0, out_valid}, 16'h0001);
      check("t3_hold_data", out_data, 16'h4080);
      check("t3_hold_ready", {15'h0, in_ready}, 16'h0000);
    end
    out_ready = 1'b1;
    tick();
    check("t3_release_valid", {15'h0, out_valid}, 16'h0000);
    check("t3_release_ready", {15'h0, in_ready}, 16'h0001);
    send(16'h4000); send(16'h4000); send(16'h4000); send(16'h4000);
    collect("t3_next", 16'h4100);

    // 4: bubbles between accepts
    send(16'h3F80); tick();
    send(16'h3F80); tick();
    send(16'h3F80); tick();
    check("t4_bubble_wait", {15'h0, out_valid}, 16'h0000);
    send(16'h3F80);
    collect("t4", 16'h4080);

    // 5: in_clear alone, then in_clear on the same cycle as an accept
    send(16'h3F80); send(16'h3F80);
    in_clear = 1'b1;
    tick();
    in_clear = 1'b0;
    send(16'h4000); send(16'h4000); send(16'h4000); send(16'h4000);
    collect("t5_clear", 16'h4100);
    send(16'h4000); send(16'h4000);
    in_clear = 1'b1;
    send(16'h3F80);
    in_clear = 1'b0;
    check("t5_clear_acc_ready", {15'h0, in_ready}, 16'h0001);
    send(16'h4000); send(16'h4000); send(16'h4000); send(16'h4000);
    collect("t5_clear_acc", 16'h4100);

    // 6: asynchronous reset between edges, in ACCUM and in DONE
    send(16'h3F80); send(16'h3F80);
    #3 rst_n = 1'b0;
    #1;
    check("t6_accum_valid", {15'h0, out_valid}, 16'h0000);
    check("t6_accum_data", out_data, 16'h0000);
    check("t6_accum_ready", {15'h0, in_ready}, 16'h0001);
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b0;
    send(16'h3F80); send(16'h3F80); send(16'h3F80); send(16'h3F80);
    check("t6_done_data", out_data, 16'h4080);
    #3 rst_n = 1'b0;
    #1;
    check("t6_done_valid", {15'h0, out_valid}, 16'h0000);
    check("t6_done_data_clr", out_data, 16'h0000);
    check("t6_done_ready", {15'h0, in_ready}, 16'h0001);
    #2 rst_n = 1'b1;
    tick();
    send(16'h4000); send(16'h4000); send(16'h4000); send(16'h4000);
    collect("t6_after", 16'h4100);

    // ACC_LEN=1: result one cycle after the single accept
    v1_in_valid = 1'b1;
    v1_in_data  = 16'h4040;
    tick();
    v1_in_valid = 1'b0;
    check("t6_len1_valid", {15'h0, v1_out_valid}, 16'h0001);
    check("t6_len1_data", v1_out_data, 16'h4040);
    check("t6_len1_ready", {15'h0, v1_in_ready}, 16'h0000);
    v1_out_ready = 1'b1;
    tick();
    check("t6_len1_drain", {15'h0, v1_out_valid}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
